// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_boot_loader_pkg;

    localparam int WORD_W     = 32;
    localparam int WORD_BYTES = 4;

    typedef enum logic [2:0] {
        HDR_HI = 3'd0,
        HDR_LO = 3'd1,
        DATA   = 3'd2,
        CHK    = 3'd3,
        RUN    = 3'd4,
        ERR    = 3'd5
    } boot_state_t;

endpackage

// File: rtl/imem_boot_loader_boot_word_assembler.sv
// Packs bytes MSB-first into 32-bit words and keeps a running XOR of every byte seen.
// Latency: word_dat/word_done appear the cycle after the 4th byte; byte_last is combinational.
// Backpressure: none, accepts a byte on every cycle byte_vld is high.
module boot_word_assembler
    import imem_boot_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              byte_vld,
    input  logic [7:0]        byte_dat,
    output logic              byte_last,
    output logic [WORD_W-1:0] word_dat,
    output logic              word_done,
    output logic [7:0]        csum
);

    logic [1:0]  byte_idx;
    logic [23:0] shift_q;

    assign byte_last = (byte_idx == 2'd3);

    // word_dat is held separately from the shift register so a byte arriving
    // in the strobe cycle cannot disturb the word being written.
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_idx  <= 2'd0;
            shift_q   <= 24'd0;
            word_dat  <= '0;
            word_done <= 1'b0;
            csum      <= 8'd0;
        end else if (clear) begin
            byte_idx  <= 2'd0;
            shift_q   <= 24'd0;
            word_done <= 1'b0;
            csum      <= 8'd0;
        end else begin
            word_done <= 1'b0;
            if (byte_vld) begin
                csum <= csum ^ byte_dat;
                if (byte_last) begin
                    word_dat  <= {shift_q, byte_dat};
                    word_done <= 1'b1;
                    byte_idx  <= 2'd0;
                end else begin
                    shift_q  <= {shift_q[15:0], byte_dat};
                    byte_idx <= byte_idx + 2'd1;
                end
            end
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Loads a counted, XOR-checksummed byte stream into instruction memory, then releases the core.
// Latency: each word is written the cycle after its 4th byte; cpu_run/load_err the cycle after the deciding byte.
// Backpressure: in_ready is high while loading and drops for good once the load passes or fails.
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_byte,
    output logic              in_ready,
    output logic              imem_we,
    output logic [31:0]       imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic [15:0]       loaded_words,
    output logic              cpu_run,
    output logic              load_err
);

    localparam logic [15:0] MAX_N  = 16'(MAX_WORDS);
    localparam logic [31:0] STRIDE = 32'(WORD_BYTES);

    boot_state_t state;
    logic [7:0]  cnt_hi;
    logic [15:0] word_total;
    logic [31:0] addr_nxt;
    logic [15:0] hdr_n;
    logic [7:0]  csum;
    logic        xfer;
    logic        asm_vld;
    logic        asm_last;
    logic        word_fire;
    logic        asm_clear;

    assign xfer      = in_valid && in_ready;
    assign hdr_n     = {cnt_hi, in_byte};
    assign asm_vld   = xfer && (state == DATA);
    assign word_fire = asm_vld && asm_last;
    assign asm_clear = xfer && (state == HDR_LO);

    boot_word_assembler u_asm (
        .clk       (clk),
        .reset     (reset),
        .clear     (asm_clear),
        .byte_vld  (asm_vld),
        .byte_dat  (in_byte),
        .byte_last (asm_last),
        .word_dat  (imem_wdata),
        .word_done (imem_we),
        .csum      (csum)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= HDR_HI;
            in_ready     <= 1'b0;
            cnt_hi       <= 8'd0;
            word_total   <= 16'd0;
            loaded_words <= 16'd0;
            imem_addr    <= BASE_ADDR;
            addr_nxt     <= BASE_ADDR;
            cpu_run      <= 1'b0;
            load_err     <= 1'b0;
        end else begin
            // The address and count land in the same cycle as the assembler's strobe.
            if (word_fire) begin
                imem_addr    <= addr_nxt;
                addr_nxt     <= addr_nxt + STRIDE;
                loaded_words <= loaded_words + 16'd1;
            end
            case (state)
                HDR_HI: begin
                    in_ready <= 1'b1;
                    if (xfer) begin
                        cnt_hi <= in_byte;
                        state  <= HDR_LO;
                    end
                end
                HDR_LO: begin
                    if (xfer) begin
                        word_total <= hdr_n;
                        if (hdr_n == 16'd0) begin
                            state <= CHK;
                        end else if (hdr_n > MAX_N) begin
                            state    <= ERR;
                            in_ready <= 1'b0;
                            load_err <= 1'b1;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (word_fire && (loaded_words + 16'd1 == word_total)) begin
                        state <= CHK;
                    end
                end
                CHK: begin
                    if (xfer) begin
                        in_ready <= 1'b0;
                        if (in_byte == csum) begin
                            state   <= RUN;
                            cpu_run <= 1'b1;
                        end else begin
                            state    <= ERR;
                            load_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
